// File: rtl/comms_mutex_bank.sv
// ---------------------------------------------------------------------------
// comms_mutex_bank
//
// Bank of NUM_MUTEX hardware mutexes behind one Avalon-MM slave. The bank is
// shared by the Car2X communication CPUs.
//
// Each mutex has a 16-bit owner ID and a 16-bit value. A write takes effect
// only when the mutex is free (value == 0) or when the writer already owns
// it. The owner releases a mutex by writing value 0.
//
// Each mutex has its own lease counter. When a holder keeps a mutex for
// LEASE_LIMIT cycles without rewriting it, the bank releases the mutex by
// force and sets a sticky EXPIRED flag. That flag can raise a maskable,
// level-sensitive interrupt.
//
// Word address map (IDX_W = clog2(NUM_MUTEX)):
//   address[IDX_W] = 0 : MUTEX[address[IDX_W-1:0]]   {owner, value}
//   address[IDX_W] = 1 : control register selected by the low bits
//        0 RESET_FLAG   reads 1 after reset; any write clears it
//        1 LEASE_LIMIT  R/W, low LEASE_W bits
//        2 EXPIRED      sticky expiry flags, write-1-to-clear
//        3 IRQ_MASK     R/W, one enable bit per mutex
//        others         read 0, writes ignored
//
// Ports:
//   clk            system clock
//   reset          asynchronous reset, active-high
//   address        word address, IDX_W+1 bits
//   chipselect     slave select
//   read           read strobe (reads have no side effects)
//   write          write strobe
//   data_from_cpu  write data
//   data_to_cpu    read data, combinational (read latency 0)
//   irq            level interrupt, |(EXPIRED & IRQ_MASK)
// ---------------------------------------------------------------------------
module comms_mutex_bank #(
   parameter int NUM_MUTEX   = 4,
   parameter int LEASE_W     = 16,
   parameter int LEASE_RESET = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(NUM_MUTEX):0]    address,
   input  logic                          chipselect,
   input  logic                          read,
   input  logic                          write,
   input  logic [31:0]                   data_from_cpu,
   output logic [31:0]                   data_to_cpu,
   output logic                          irq
);

   localparam int IDX_W = $clog2(NUM_MUTEX);

   localparam logic [IDX_W-1:0] REG_RESET_FLAG  = IDX_W'(0);
   localparam logic [IDX_W-1:0] REG_LEASE_LIMIT = IDX_W'(1);
   localparam logic [IDX_W-1:0] REG_EXPIRED     = IDX_W'(2);
   localparam logic [IDX_W-1:0] REG_IRQ_MASK    = IDX_W'(3);

   logic [15:0]          owner [NUM_MUTEX];
   logic [15:0]          value [NUM_MUTEX];
   logic [LEASE_W-1:0]   cnt   [NUM_MUTEX];

   logic                 reset_flag;
   logic [LEASE_W-1:0]   lease_limit;
   logic [NUM_MUTEX-1:0] expired;
   logic [NUM_MUTEX-1:0] irq_mask;

   logic                 wr_en;
   logic                 ctrl_wr;
   logic [IDX_W-1:0]     idx;
   logic [NUM_MUTEX-1:0] accept;
   logic [NUM_MUTEX-1:0] expire;
   logic [NUM_MUTEX-1:0] expired_clr;

   // Reads have no side effects, so the read strobe does not change any state.
   logic unused_read;
   assign unused_read = read;

   assign wr_en   = chipselect & write;
   assign idx     = address[IDX_W-1:0];
   assign ctrl_wr = wr_en & address[IDX_W];

   // A write is accepted when the mutex is free or the writer already owns it.
   // A lease expires when the counter is at its last cycle and no accepted
   // write hits that mutex in the same cycle. The write wins that race, so the
   // owner can always renew on the final cycle.
   always_comb begin
      accept = '0;
      expire = '0;
      for (int i = 0; i < NUM_MUTEX; i++) begin
         accept[i] = wr_en && !address[IDX_W] && (idx == IDX_W'(i)) &&
                     ((value[i] == 16'h0000) || (owner[i] == data_from_cpu[31:16]));
         expire[i] = !accept[i] && (value[i] != 16'h0000) &&
                     (cnt[i] == LEASE_W'(1));
      end
   end

   always_comb begin
      expired_clr = '0;
      if (ctrl_wr && (idx == REG_EXPIRED)) begin
         expired_clr = data_from_cpu[NUM_MUTEX-1:0];
      end
   end

   // Mutex state and lease counters.
   // The counter reloads from the LEASE_LIMIT value in force at acquire time,
   // so a later change to LEASE_LIMIT leaves running leases alone. A limit of
   // 0 loads a 0 counter, which never reaches the expiry value of 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_MUTEX; i++) begin
            owner[i] <= '0;
            value[i] <= '0;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_MUTEX; i++) begin
            if (accept[i]) begin
               owner[i] <= data_from_cpu[31:16];
               value[i] <= data_from_cpu[15:0];
               if (data_from_cpu[15:0] != 16'h0000) begin
                  cnt[i] <= lease_limit;
               end else begin
                  cnt[i] <= '0;
               end
            end else if (expire[i]) begin
               owner[i] <= '0;
               value[i] <= '0;
               cnt[i]   <= '0;
            end else if ((value[i] != 16'h0000) && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - LEASE_W'(1);
            end
         end
      end
   end

   // Control registers.
   // In EXPIRED, a set from a new expiry takes priority over a
   // write-1-to-clear of the same bit in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reset_flag  <= 1'b1;
         lease_limit <= LEASE_W'(LEASE_RESET);
         expired     <= '0;
         irq_mask    <= '0;
      end else begin
         if (ctrl_wr) begin
            case (idx)
               REG_RESET_FLAG:  reset_flag  <= 1'b0;
               REG_LEASE_LIMIT: lease_limit <= data_from_cpu[LEASE_W-1:0];
               REG_IRQ_MASK:    irq_mask    <= data_from_cpu[NUM_MUTEX-1:0];
               default: ;
            endcase
         end
         expired <= (expired & ~expired_clr) | expire;
      end
   end

   assign irq = |(expired & irq_mask);

   // Read mux. The output is combinational, so a read in the same cycle as a
   // write returns the value from before that write.
   always_comb begin
      data_to_cpu = '0;
      if (!address[IDX_W]) begin
         data_to_cpu = {owner[idx], value[idx]};
      end else begin
         case (idx)
            REG_RESET_FLAG:  data_to_cpu = {31'd0, reset_flag};
            REG_LEASE_LIMIT: data_to_cpu = 32'(lease_limit);
            REG_EXPIRED:     data_to_cpu = 32'(expired);
            REG_IRQ_MASK:    data_to_cpu = 32'(irq_mask);
            default:         data_to_cpu = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_comms_mutex_bank.sv
module tb_comms_mutex_bank;

   localparam int NM = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] data_from_cpu = '0;
   logic [31:0] data_to_cpu;
   logic        irq;

   int checks = 0;
   int errors = 0;

   comms_mutex_bank #(.NUM_MUTEX(NM), .LEASE_W(16), .LEASE_RESET(0)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write(write), .data_from_cpu(data_from_cpu),
      .data_to_cpu(data_to_cpu), .irq(irq)
   );

   always #5 clk = ~clk;

   // Behavioural model. Each lease is tracked as an absolute deadline cycle,
   // not as a counter.
   longint      cyc = 0;
   logic [15:0] m_owner [NM];
   logic [15:0] m_value [NM];
   longint      m_deadline [NM];
   logic        m_flag = 1'b1;
   logic [15:0] m_limit = '0;
   logic [3:0]  m_expired = '0;
   logic [3:0]  m_mask = '0;

   initial begin
      for (int i = 0; i < NM; i++) begin
         m_owner[i] = '0; m_value[i] = '0; m_deadline[i] = 0;
      end
   end

   always @(posedge clk or posedge reset) begin
      logic [3:0] exp_set;
      logic       acc;
      cyc = cyc + 1;
      if (reset) begin
         for (int i = 0; i < NM; i++) begin
            m_owner[i] = '0; m_value[i] = '0; m_deadline[i] = 0;
         end
         m_flag = 1'b1; m_limit = '0; m_expired = '0; m_mask = '0;
      end else begin
         exp_set = '0;
         for (int i = 0; i < NM; i++) begin
            acc = chipselect && write && !address[2] && (address[1:0] == i[1:0]) &&
                  (m_value[i] == 0 || m_owner[i] == data_from_cpu[31:16]);
            if (acc) begin
               m_owner[i] = data_from_cpu[31:16];
               m_value[i] = data_from_cpu[15:0];
               m_deadline[i] = (data_from_cpu[15:0] != 0 && m_limit != 0) ?
                               cyc + longint'(m_limit) : 0;
            end else if (m_value[i] != 0 && m_deadline[i] != 0 && m_deadline[i] == cyc) begin
               m_owner[i] = '0; m_value[i] = '0; m_deadline[i] = 0;
               exp_set[i] = 1'b1;
            end
         end
         if (chipselect && write && address[2]) begin
            case (address[1:0])
               2'd0: m_flag = 1'b0;
               2'd1: m_limit = data_from_cpu[15:0];
               2'd2: m_expired = m_expired & ~data_from_cpu[3:0];
               2'd3: m_mask = data_from_cpu[3:0];
               default: ;
            endcase
         end
         m_expired = m_expired | exp_set;
      end
   end

   function automatic logic [31:0] model_read(input logic [2:0] a);
      if (!a[2]) return {m_owner[a[1:0]], m_value[a[1:0]]};
      case (a[1:0])
         2'd0: return {31'd0, m_flag};
         2'd1: return {16'd0, m_limit};
         2'd2: return {28'd0, m_expired};
         default: return {28'd0, m_mask};
      endcase
   endfunction

   // Compare process: on every falling edge, check the read data and irq against the model.
   always @(negedge clk) begin
      checks++;
      if (data_to_cpu !== model_read(address)) begin
         errors++;
         $display("FAIL model_rd a=%0d: got %h expected %h", address, data_to_cpu, model_read(address));
      end
      checks++;
      if (irq !== |(m_expired & m_mask)) begin
         errors++;
         $display("FAIL model_irq: got %b expected %b", irq, |(m_expired & m_mask));
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; data_from_cpu = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0; data_from_cpu = '0;
   endtask

   task automatic wr_nocs(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b0; write = 1'b1; address = a; data_from_cpu = d;
      @(posedge clk); #1;
      write = 1'b0; data_from_cpu = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string name);
      address = a; read = 1'b1; chipselect = 1'b1;
      #1;
      checks++;
      if (data_to_cpu !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, data_to_cpu, exp);
      end
      read = 1'b0; chipselect = 1'b0;
   endtask

   task automatic irq_check(input logic exp, input string name);
      checks++;
      if (irq !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, irq, exp);
      end
   endtask

   initial begin
      #2 reset = 1'b1;
      #10 reset = 1'b0;
      @(posedge clk); #1;

      rd_check(3'd4, 32'h1, "reset_flag_1");
      rd_check(3'd2, 32'h0, "mutex2_reset");
      rd_check(3'd5, 32'h0, "lease_reset");
      irq_check(1'b0, "irq_reset");
      wr(3'd4, 32'h0);
      rd_check(3'd4, 32'h0, "reset_flag_cleared");

      wr_nocs(3'd0, 32'h00770001);
      rd_check(3'd0, 32'h0, "no_cs_write");

      wr(3'd1, 32'h00AA0005);
      rd_check(3'd1, 32'h00AA0005, "m1_acquire");
      wr(3'd1, 32'h00BB0007);
      rd_check(3'd1, 32'h00AA0005, "m1_foreign");
      wr(3'd1, 32'h00AA0000);
      rd_check(3'd1, 32'h00AA0000, "m1_release");
      wr(3'd1, 32'h00BB0003);
      rd_check(3'd1, 32'h00BB0003, "m1_reacquire");

      // Lease expiry: acquire with a limit of 10; the expiry happens at T+10.
      wr(3'd5, 32'd10);
      wr(3'd7, 32'h4);
      wr(3'd2, 32'h00110001);
      idle(9);
      rd_check(3'd2, 32'h00110001, "lease_t9");
      idle(1);
      rd_check(3'd2, 32'h0, "lease_t10");
      rd_check(3'd6, 32'h4, "expired_set");
      irq_check(1'b1, "irq_set");
      wr(3'd6, 32'h4);
      irq_check(1'b0, "irq_w1c");
      rd_check(3'd6, 32'h0, "expired_w1c");

      // Owner renews exactly on the last lease cycle, so the mutex is not released.
      wr(3'd5, 32'd5);
      wr(3'd2, 32'h00110001);
      idle(4);
      wr(3'd2, 32'h00110002);
      rd_check(3'd2, 32'h00110002, "renew_held");
      rd_check(3'd6, 32'h0, "renew_no_expiry");
      idle(4);
      rd_check(3'd2, 32'h00110002, "renew_t4");
      idle(1);
      rd_check(3'd2, 32'h0, "renew_release");
      rd_check(3'd6, 32'h4, "renew_expired");
      wr(3'd6, 32'hF);

      // A lease limit of 0 means the lease never expires.
      wr(3'd5, 32'd0);
      wr(3'd3, 32'h00330009);
      idle(70000);
      rd_check(3'd3, 32'h00330009, "nolease_held");
      rd_check(3'd6, 32'h0, "nolease_expired");

      // Assert reset in the middle of a lease, with cnt = 3.
      wr(3'd5, 32'd8);
      wr(3'd7, 32'hF);
      wr(3'd0, 32'h00010001);
      idle(5);
      reset = 1'b1;
      #1;
      rd_check(3'd0, 32'h0, "rst_m0");
      rd_check(3'd1, 32'h0, "rst_m1");
      rd_check(3'd3, 32'h0, "rst_m3");
      rd_check(3'd4, 32'h1, "rst_flag");
      rd_check(3'd5, 32'h0, "rst_lease");
      rd_check(3'd7, 32'h0, "rst_mask");
      reset = 1'b0;
      idle(6);
      rd_check(3'd6, 32'h0, "rst_no_expiry");
      irq_check(1'b0, "rst_irq");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
